// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: takes parallel words over valid/ready and shifts
// them out MSB-first on a registered serial line. It also produces the 010/101
// completion flags a Mealy detector fed from this line should raise, plus
// saturating match counts, for bit-exact cross-checking of the detector.
module serial_pattern_tx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             o,
    output logic             busy,
    output logic [1:0]       expect_flags,
    output logic [7:0]       count_010,
    output logic [7:0]       count_101
);

    localparam int unsigned BcW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BcW-1:0]   bc_q, bc_d;
    logic             o_q, o_d;
    logic             h1_q, h2_q;
    logic [1:0]       hv_q, hv_d;
    logic [7:0]       count_010_q, count_010_d;
    logic [7:0]       count_101_q, count_101_d;
    logic             accept;

    // Ready depends only on state so a word can be accepted on the last-bit edge.
    always_comb begin
        ready  = (state_q == StIdle) || (bc_q == '0);
        accept = valid && ready;
    end

    // Shifter next-state: load on accept, shift while bits remain, else idle at 0.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bc_d    = bc_q;
        o_d     = 1'b0;
        if (accept) begin
            state_d = StShift;
            o_d     = data[WIDTH-1];
            sr_d    = data << 1;
            bc_d    = BcW'(WIDTH - 1);
        end else if (state_q == StShift && bc_q != '0) begin
            o_d  = sr_q[WIDTH-1];
            sr_d = sr_q << 1;
            bc_d = bc_q - BcW'(1);
        end else begin
            state_d = StIdle;
        end
    end

    // Expected detector flags; suppressed until two past line bits exist.
    always_comb begin
        expect_flags    = 2'b00;
        expect_flags[1] = (hv_q == 2'd2) && !h2_q && h1_q && !o_q;
        expect_flags[0] = (hv_q == 2'd2) && h2_q && !h1_q && o_q;
    end

    // Saturating match counters and history-valid counter.
    always_comb begin
        count_010_d = count_010_q;
        count_101_d = count_101_q;
        hv_d        = (hv_q == 2'd2) ? 2'd2 : hv_q + 2'd1;
        if (expect_flags[1] && count_010_q != 8'hFF) count_010_d = count_010_q + 8'd1;
        if (expect_flags[0] && count_101_q != 8'hFF) count_101_d = count_101_q + 8'd1;
    end

    // State register; history shifts every cycle, idle zeros included.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            bc_q        <= '0;
            o_q         <= 1'b0;
            h1_q        <= 1'b0;
            h2_q        <= 1'b0;
            hv_q        <= 2'd0;
            count_010_q <= 8'd0;
            count_101_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bc_q        <= bc_d;
            o_q         <= o_d;
            h1_q        <= o_q;
            h2_q        <= h1_q;
            hv_q        <= hv_d;
            count_010_q <= count_010_d;
            count_101_q <= count_101_d;
        end
    end

    // Output drive.
    always_comb begin
        o         = o_q;
        busy      = (state_q == StShift);
        count_010 = count_010_q;
        count_101 = count_101_q;
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: directed scenarios plus random
// traffic, compared every cycle against a bit-queue reference model.
module tb_serial_pattern_tx;

    localparam int unsigned W = 8;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] data = '0;
    logic         valid = 1'b0;
    logic         ready, o, busy;
    logic [1:0]   expect_flags;
    logic [7:0]   count_010, count_101;

    int vectors = 0;
    int errors  = 0;

    // Reference model: queued line bits, last three line values, match tallies.
    bit   pend[$];
    bit   line[$];
    int   cyc;
    bit   m_o, m_busy, m_ready;
    int   m_c010, m_c101;

    serial_pattern_tx #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .data         (data),
        .valid        (valid),
        .ready        (ready),
        .o            (o),
        .busy         (busy),
        .expect_flags (expect_flags),
        .count_010    (count_010),
        .count_101    (count_101)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_expect();
        logic [1:0] e;
        e = 2'b00;
        if (cyc >= 2) begin
            e[1] = (line[0] == 0) && (line[1] == 1) && (line[2] == 0);
            e[0] = (line[0] == 1) && (line[1] == 0) && (line[2] == 1);
        end
        return e;
    endfunction

    task automatic model_reset();
        pend.delete();
        line    = '{0, 0, 0};
        cyc     = 0;
        m_o     = 0;
        m_busy  = 0;
        m_ready = 1;
        m_c010  = 0;
        m_c101  = 0;
    endtask

    task automatic model_edge();
        logic [1:0] e;
        e = m_expect();
        if (e[1] && m_c010 < 255) m_c010++;
        if (e[0] && m_c101 < 255) m_c101++;
        if (valid && m_ready)
            for (int i = W - 1; i >= 0; i--) pend.push_back(data[i]);
        if (pend.size() > 0) begin
            m_o    = pend.pop_front();
            m_busy = 1;
        end else begin
            m_o    = 0;
            m_busy = 0;
        end
        line.push_back(m_o);
        void'(line.pop_front());
        if (cyc < 2) cyc++;
        m_ready = (pend.size() == 0);
    endtask

    task automatic check_all();
        check_val("o", o, m_o);
        check_val("busy", busy, m_busy);
        check_val("ready", ready, m_ready);
        check_val("expect", expect_flags, m_expect());
        check_val("count_010", count_010, m_c010);
        check_val("count_101", count_101, m_c101);
    endtask

    task automatic step();
        @(posedge clock);
        if (reset_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Present a word and wait until it is accepted; valid stays high on return.
    task automatic send_word(input logic [W-1:0] w);
        bit acc;
        int n;
        valid = 1'b1;
        data  = w;
        n     = 0;
        do begin
            acc = m_ready;
            step();
            n++;
        end while (!acc && n < 2 * W + 4);
        if (!acc) check_val("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            data = W'($urandom);
            step();
        end
    endtask

    initial begin
        model_reset();
        #2;
        // Reset and idle with toggling data.
        do_reset();
        idle(10);
        check_val("idle_o", o, 0);
        check_val("idle_ready", ready, 1);

        // Single word 0101_0000.
        do_reset();
        idle(3);
        send_word(8'b0101_0000);
        idle(10);
        check_val("single_c010", count_010, 2);
        check_val("single_c101", count_101, 1);

        // Back-to-back A5 then 5A.
        do_reset();
        idle(3);
        send_word(8'hA5);
        send_word(8'h5A);
        idle(12);
        check_val("b2b_c010", count_010, 6);
        check_val("b2b_c101", count_101, 5);

        // Reset during the fourth bit of FF, then 81.
        do_reset();
        idle(2);
        send_word(8'hFF);
        valid = 1'b0;
        step();
        step();
        step();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_mid_o", o, 0);
        check_val("rst_mid_busy", busy, 0);
        check_val("rst_mid_c010", count_010, 0);
        check_val("rst_mid_c101", count_101, 0);
        step();
        reset_n = 1'b1;
        idle(2);
        send_word(8'h81);
        idle(10);

        // Saturation: enough alternating bits to pass 255 completions each.
        do_reset();
        idle(2);
        for (int i = 0; i < 70; i++) send_word(8'h55);
        idle(10);
        check_val("sat_c010", count_010, 255);
        check_val("sat_c101", count_101, 255);

        // Ignored valid during shift.
        do_reset();
        idle(2);
        send_word(8'hF0);
        valid = 1'b0;
        step();
        step();
        valid = 1'b1;
        data  = 8'h0F;
        step();
        valid = 1'b0;
        idle(12);
        check_val("ignored_busy", busy, 0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            valid = 1'($urandom);
            data  = W'($urandom);
            step();
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
